regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single synchronous write port between two requesters.
  - Requester A: pipeline writeback stage.
  - Requester B: multi-cycle unit / debug loader.
- Each requester has a valid/ready handshake and a one-entry holding slot.
- Arbitration is fixed-priority to A, with anti-starvation for B.
- Drives registered write-enable/dest/data and an 8-bit pending-write mask for the hazard unit.

Parameters:
- STARVE_LIMIT, 4: consecutive contended cycles A may win before B is forced; legal range 1..(2^CNT_W - 1).
- CNT_W, 3: width of the starvation counter.
- STATS_W, 16: width of the statistics counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- a_valid  in  1  requester A write request.
- a_ready  out  1  A slot can accept this cycle.
- a_dest  in  3  A destination register.
- a_data  in  16  A write data.
- b_valid  in  1  requester B write request.
- b_ready  out  1  B slot can accept this cycle.
- b_dest  in  3  B destination register.
- b_data  in  16  B write data.
- reg_write_en  out  1  to register file write enable (registered).
- reg_write_dest  out  3  to register file write address (registered).
- reg_write_data  out  16  to register file write data (registered).
- pending_mask  out  8  bit i = 1 while a write to register i is buffered or being driven.

Behaviour:
- Reset (async, rst=1):
  - Both slots empty; starvation counter = 0.
  - reg_write_en = 0, reg_write_dest = 0, reg_write_data = 0.
  - pending_mask = 0.
  - Any buffered write is discarded. Reset mid-operation never produces a write after deassertion.
- Handshake:
  - Transfer occurs when x_valid && x_ready at a rising edge.
  - x_ready = !x_full || x_granted. Combinational, from registered state only; never depends on x_valid.
  - A full slot granted this cycle may be refilled on the same edge, so one requester sustains 1 write/cycle.
- Arbitration (each cycle, over full slots):
  - Only A full: grant A.
  - Only B full: grant B.
  - Both full and counter < STARVE_LIMIT: grant A; counter += 1.
  - Both full and counter == STARVE_LIMIT: grant B; counter = 0.
  - Counter clears whenever B is granted or B's slot is empty; otherwise it holds. It never exceeds STARVE_LIMIT.
- Commit:
  - The granted slot empties at the edge.
  - Output registers load dest and data.
  - reg_write_en = 1 only if dest != 0. A write to r0 is accepted and consumed but never enabled.
  - With no grant, reg_write_en = 0 next cycle; dest/data hold their last values.
- Latency: accept at edge N → slot full in cycle N+1, grant in N+1 (if it wins) → reg_write_en high in cycle N+2 → register file updated at the end of N+2.
- pending_mask:
  - OR of one-hot(dest) over full slots, plus one-hot(reg_write_dest) when reg_write_en = 1.
  - Bit 0 is always 0.
  - Combinational from registered state.
- Same destination in both slots: commit order equals grant order; the later grant is the final register value.
- Simultaneous a_valid and b_valid with both slots empty: both are accepted; A commits first unless the forced-B condition holds.
- Requesters must hold valid/dest/data stable until ready. Behaviour on a violation is undefined (assertion in the bench).

Optional Feature:
- Macro: REGFILE_WR_STATS_EN.
- Defined: adds three outputs, each STATS_W bits, wrapping at 2^STATS_W, cleared by rst:
  - a_commit_cnt: increments per A grant.
  - b_commit_cnt: increments per B grant.
  - r0_drop_cnt: increments per grant with dest == 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-stream with both slots full (A: r3=0x1234, B: r5=0xBEEF) → after deassert, all outputs 0, pending_mask = 0x00, no reg_write_en pulse ever follows.
- Single A: a_valid with r2=0xA5A5 at edge N → a_ready stays 1, pending_mask = 0x04 in cycles N+1..N+2; reg_write_en = 1, dest = 2, data = 0xA5A5 in cycle N+2 only.
- Back-to-back: A streams r1..r7 on 7 consecutive edges → reg_write_en high for 7 consecutive cycles, dests 1..7 in order, a_ready never drops.
- Starvation (STARVE_LIMIT = 4): A streams continuously to r1 and B holds r6=0x0F0F → commit sequence is A,A,A,A,B,A,…; B commits in its 5th contended cycle; b_ready rises the same cycle.
- Same destination: A and B both write r4 (A=0x1111, B=0x2222) with both slots empty → A commits, then B; final r4 = 0x2222; pending_mask bit 4 stays set until the B write is driven.
- r0 discard: B writes r0=0xFFFF → b_ready handshake completes, reg_write_en stays 0, pending_mask stays 0x00; r0_drop_cnt = 1 when REGFILE_WR_STATS_EN is defined.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the register file's single write port: per-requester holding slot,
// A-priority with forced B after STARVE_LIMIT contended cycles. Optional stats via REGFILE_WR_STATS_EN.

module regfile_wr_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [2:0]  dest,
  input  logic [15:0] data,
  input  logic        grant,
  output logic        ready,
  output logic        full,
  output logic [2:0]  slot_dest,
  output logic [15:0] slot_data
);
  // A granted slot frees this edge, so it can take a new entry at the same time.
  assign ready = !full || grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= 1'b0;
      slot_dest <= '0;
      slot_data <= '0;
    end else if (valid && ready) begin
      full      <= 1'b1;
      slot_dest <= dest;
      slot_data <= data;
    end else if (grant) begin
      full      <= 1'b0;
    end
  end
endmodule

module regfile_write_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3,
  parameter int STATS_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [2:0]         a_dest,
  input  logic [15:0]        a_data,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [2:0]         b_dest,
  input  logic [15:0]        b_data,
  output logic               reg_write_en,
  output logic [2:0]         reg_write_dest,
  output logic [15:0]        reg_write_data,
  output logic [7:0]         pending_mask
`ifdef REGFILE_WR_STATS_EN
  ,
  output logic [STATS_W-1:0] a_commit_cnt,
  output logic [STATS_W-1:0] b_commit_cnt,
  output logic [STATS_W-1:0] r0_drop_cnt
`endif
);
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > (1 << CNT_W) - 1 || STATS_W < 1) begin : g_param_check
    $error("regfile_write_arbiter: illegal STARVE_LIMIT/CNT_W/STATS_W");
  end

  logic        a_full, b_full, grant_a, grant_b, starve;
  logic [2:0]  a_sdest, b_sdest;
  logic [15:0] a_sdata, b_sdata;
  logic [CNT_W-1:0] cnt;

  regfile_wr_slot u_slot_a (
    .clk(clk), .rst(rst), .valid(a_valid), .dest(a_dest), .data(a_data), .grant(grant_a),
    .ready(a_ready), .full(a_full), .slot_dest(a_sdest), .slot_data(a_sdata)
  );

  regfile_wr_slot u_slot_b (
    .clk(clk), .rst(rst), .valid(b_valid), .dest(b_dest), .data(b_data), .grant(grant_b),
    .ready(b_ready), .full(b_full), .slot_dest(b_sdest), .slot_data(b_sdata)
  );

  assign starve  = (cnt == CNT_W'(STARVE_LIMIT));
  assign grant_a = a_full && !(b_full && starve);
  assign grant_b = b_full && (!a_full || starve);

  // Counts only cycles where B waits behind A; any other cycle resets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (b_full && grant_a) cnt <= cnt + 1'b1;
    else                        cnt <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_en   <= 1'b0;
      reg_write_dest <= '0;
      reg_write_data <= '0;
    end else if (grant_a) begin
      reg_write_en   <= (a_sdest != 3'd0);
      reg_write_dest <= a_sdest;
      reg_write_data <= a_sdata;
    end else if (grant_b) begin
      reg_write_en   <= (b_sdest != 3'd0);
      reg_write_dest <= b_sdest;
      reg_write_data <= b_sdata;
    end else begin
      reg_write_en   <= 1'b0;
    end
  end

  always_comb begin
    pending_mask = '0;
    if (a_full)       pending_mask[a_sdest]        = 1'b1;
    if (b_full)       pending_mask[b_sdest]        = 1'b1;
    if (reg_write_en) pending_mask[reg_write_dest] = 1'b1;
    pending_mask[0] = 1'b0;
  end

`ifdef REGFILE_WR_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_commit_cnt <= '0;
      b_commit_cnt <= '0;
      r0_drop_cnt  <= '0;
    end else begin
      if (grant_a) a_commit_cnt <= a_commit_cnt + 1'b1;
      if (grant_b) b_commit_cnt <= b_commit_cnt + 1'b1;
      if ((grant_a && a_sdest == 3'd0) || (grant_b && b_sdest == 3'd0))
        r0_drop_cnt <= r0_drop_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single/streamed A, starvation, same-dest, r0 drop.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [2:0]  a_dest = '0, b_dest = '0;
  logic [15:0] a_data = '0, b_data = '0;
  logic        reg_write_en;
  logic [2:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic [7:0]  pending_mask;
`ifdef REGFILE_WR_STATS_EN
  logic [15:0] a_commit_cnt, b_commit_cnt, r0_drop_cnt;
`endif
  int checks = 0, errors = 0;
  logic [15:0] rf [8];

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_dest(a_dest), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_data(b_data),
    .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
    .reg_write_data(reg_write_data), .pending_mask(pending_mask)
`ifdef REGFILE_WR_STATS_EN
    , .a_commit_cnt(a_commit_cnt), .b_commit_cnt(b_commit_cnt), .r0_drop_cnt(r0_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Register file that consumes the write port.
  always @(posedge clk) if (reg_write_en) rf[reg_write_dest] <= reg_write_data;

  // Requesters must hold valid/dest/data while stalled.
  logic        a_hold = 1'b0, b_hold = 1'b0;
  logic [18:0] a_prev, b_prev;
  always @(posedge clk) begin
    if (!rst && a_hold) assert (a_valid && {a_dest, a_data} == a_prev) else $error("A request changed while stalled");
    if (!rst && b_hold) assert (b_valid && {b_dest, b_data} == b_prev) else $error("B request changed while stalled");
    a_hold <= a_valid && !a_ready;
    b_hold <= b_valid && !b_ready;
    a_prev <= {a_dest, a_data};
    b_prev <= {b_dest, b_data};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_out(input string tag, input logic en, input logic [2:0] d, input logic [15:0] v);
    chk({tag, ".en"}, reg_write_en, en);
    if (en) begin
      chk({tag, ".dest"}, reg_write_dest, d);
      chk({tag, ".data"}, reg_write_data, v);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = '0;
    // ---- reset state
    #1;
    chk("rst.en", reg_write_en, 0);
    chk("rst.dest", reg_write_dest, 0);
    chk("rst.data", reg_write_data, 0);
    chk("rst.mask", pending_mask, 0);
    tick(); tick();
    rst = 1'b0;
    // ---- reset mid-stream with both slots full
    a_valid = 1; a_dest = 3; a_data = 16'h1234;
    b_valid = 1; b_dest = 5; b_data = 16'hBEEF;
    tick();
    a_valid = 0; b_valid = 0;
    chk("rst2.mask_full", pending_mask, 8'h28);
    rst = 1'b1; #1;
    chk("rst2.en", reg_write_en, 0);
    chk("rst2.dest", reg_write_dest, 0);
    chk("rst2.data", reg_write_data, 0);
    chk("rst2.mask", pending_mask, 0);
    chk("rst2.a_ready", a_ready, 1);
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst2.no_write", reg_write_en, 0);
      chk("rst2.mask_after", pending_mask, 0);
    end

    // ---- single A write r2
    a_valid = 1; a_dest = 2; a_data = 16'hA5A5;
    chk("single.a_ready", a_ready, 1);
    tick();
    a_valid = 0;
    chk("single.a_ready1", a_ready, 1);
    chk("single.mask1", pending_mask, 8'h04);
    chk("single.en1", reg_write_en, 0);
    tick();
    chk_out("single.c2", 1, 2, 16'hA5A5);
    chk("single.mask2", pending_mask, 8'h04);
    tick();
    chk("single.en3", reg_write_en, 0);
    chk("single.mask3", pending_mask, 8'h00);

    // ---- back-to-back r1..r7
    for (int k = 0; k < 9; k++) begin
      a_valid = (k < 7);
      a_dest  = 3'(k + 1);
      a_data  = 16'(16'h0100 * (k + 1));
      if (k < 7) chk("b2b.a_ready", a_ready, 1);
      tick();
      if (k >= 1 && k <= 7) chk_out("b2b.out", 1, 3'(k), 16'(16'h0100 * k));
      else chk("b2b.idle", reg_write_en, 0);
    end
    a_valid = 0;

    // ---- starvation: A streams r1, B holds r6
    a_valid = 1; a_dest = 1; a_data = 16'h0A0A;
    b_valid = 1; b_dest = 6; b_data = 16'h0F0F;
    chk("starve.b_ready0", b_ready, 1);
    tick();                          // k=0: both accepted
    b_valid = 0;
    chk("starve.k0.b_ready", b_ready, 0);
    chk("starve.k0.en", reg_write_en, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) chk_out("starve.b_commit", 1, 6, 16'h0F0F);
      else        chk_out("starve.a_commit", 1, 1, 16'h0A0A);
      chk("starve.b_ready", b_ready, (k >= 4) ? 1 : 0);
      if (k == 4) begin
        chk("starve.k4.a_ready", a_ready, 0);
        chk("starve.k4.mask", pending_mask, 8'h42);
      end
    end
    a_valid = 0;
    tick();
    chk_out("starve.drain", 1, 1, 16'h0A0A);
    tick();
    chk("starve.idle", reg_write_en, 0);
    chk("starve.mask_idle", pending_mask, 0);

    // ---- same destination r4 from both
    a_valid = 1; a_dest = 4; a_data = 16'h1111;
    b_valid = 1; b_dest = 4; b_data = 16'h2222;
    tick();
    a_valid = 0; b_valid = 0;
    chk("same.mask0", pending_mask, 8'h10);
    tick();
    chk_out("same.first", 1, 4, 16'h1111);
    chk("same.mask1", pending_mask, 8'h10);
    tick();
    chk_out("same.second", 1, 4, 16'h2222);
    chk("same.mask2", pending_mask, 8'h10);
    tick();
    chk("same.idle", reg_write_en, 0);
    chk("same.mask3", pending_mask, 0);
    chk("same.rf4", rf[4], 16'h2222);

    // ---- r0 discard
    b_valid = 1; b_dest = 0; b_data = 16'hFFFF;
    chk("r0.b_ready", b_ready, 1);
    tick();
    b_valid = 0;
    chk("r0.mask1", pending_mask, 0);
    chk("r0.en1", reg_write_en, 0);
    tick();
    chk("r0.en2", reg_write_en, 0);
    chk("r0.mask2", pending_mask, 0);
    chk("r0.b_ready2", b_ready, 1);
    tick();
    chk("r0.en3", reg_write_en, 0);
    chk("r0.rf0", rf[0], 16'h0000);
`ifdef REGFILE_WR_STATS_EN
    chk("stats.r0_drop", r0_drop_cnt, 1);
    chk("stats.b_commit", b_commit_cnt, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
